// File: rtl/edsac_pkg.sv
// Shared constants and types for the EDSAC initial-orders loading path.
package edsac_pkg;

  localparam int unsigned WORD_BITS_SHORT    = 17;
  localparam int unsigned INITIAL_ORDERS_LEN = 31;
  localparam int unsigned STORE_ADDR_W       = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/initial_orders_sequencer_io_word_assembler.sv
// Serial-to-parallel assembler: builds one short word LSB first and flags the
// cycle its final bit is accepted.
module io_word_assembler
  import edsac_pkg::*;
#(
  parameter int unsigned WORD_BITS = WORD_BITS_SHORT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_done_c
);

  localparam int unsigned      CNT_W    = cnt_w(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic [CNT_W-1:0] bit_cnt;

  assign word_done_c = shift_en && (bit_cnt == LAST_BIT);

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      word    <= {bit_in, word[WORD_BITS-1:1]};
      bit_cnt <= word_done_c ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/initial_orders_sequencer.sv
// Start-up controller: clears sequence control, loads the serial initial orders
// into store from address 0, then releases the starter and flags boot.
module initial_orders_sequencer
  import edsac_pkg::*;
#(
  parameter int unsigned WORD_BITS  = WORD_BITS_SHORT,
  parameter int unsigned NUM_ORDERS = INITIAL_ORDERS_LEN,
  parameter int unsigned ADDR_W     = STORE_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_req,
  input  logic                 serial_in,
  input  logic                 serial_valid,
  output logic                 serial_ready,
  output logic                 st_we,
  output logic [ADDR_W-1:0]    st_addr,
  output logic [WORD_BITS-1:0] st_data,
  input  logic                 st_ack,
  output logic                 reset_sct,
  output logic                 starter,
  output logic                 boot_valid,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ORDERS - 1);

  if ((NUM_ORDERS == 0) || (NUM_ORDERS > (32'd1 << ADDR_W))) begin : g_cfg_check
    $error("initial_orders_sequencer: NUM_ORDERS must lie in 1..2**ADDR_W");
  end

  seq_state_e           state_q, state_nx;
  logic                 start_d;
  logic                 start_edge_c;
  logic                 shift_en_c;
  logic                 word_done_c;
  logic                 clear_c;
  logic [WORD_BITS-1:0] word;
  logic [ADDR_W-1:0]    word_cnt_q, word_cnt_nx;

  logic serial_ready_nx, st_we_nx, reset_sct_nx, starter_nx, boot_valid_nx, busy_nx;

  assign start_edge_c = start && !start_d;
  assign clear_c      = (state_q == CLEAR);
  // An abort cycle accepts no further bits.
  assign shift_en_c   = (state_q == SHIFT) && serial_valid && !stop_req;

  io_word_assembler #(
    .WORD_BITS (WORD_BITS)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_c),
    .shift_en    (shift_en_c),
    .bit_in      (serial_in),
    .word        (word),
    .word_done_c (word_done_c)
  );

  // Next state and word counter; stop_req outranks st_ack while loading.
  always_comb begin
    state_nx    = state_q;
    word_cnt_nx = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_edge_c) state_nx = CLEAR;
      end
      CLEAR: begin
        word_cnt_nx = '0;
        state_nx    = stop_req ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (stop_req)         state_nx = IDLE;
        else if (word_done_c) state_nx = WRITE;
      end
      WRITE: begin
        if (stop_req) begin
          state_nx = IDLE;
        end else if (st_ack) begin
          if (word_cnt_q == LAST_ADDR) begin
            state_nx = DONE;
          end else begin
            word_cnt_nx = word_cnt_q + ADDR_W'(1);
            state_nx    = SHIFT;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    serial_ready_nx = (state_nx == SHIFT);
    st_we_nx        = (state_nx == WRITE);
    reset_sct_nx    = (state_nx == CLEAR);
    starter_nx      = (state_nx == CLEAR) || (state_nx == SHIFT) || (state_nx == WRITE);
    boot_valid_nx   = (state_nx == DONE);
    busy_nx         = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_d      <= 1'b0;
      word_cnt_q   <= '0;
      serial_ready <= 1'b0;
      st_we        <= 1'b0;
      reset_sct    <= 1'b0;
      starter      <= 1'b0;
      boot_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_nx;
      start_d      <= start;
      word_cnt_q   <= word_cnt_nx;
      serial_ready <= serial_ready_nx;
      st_we        <= st_we_nx;
      reset_sct    <= reset_sct_nx;
      starter      <= starter_nx;
      boot_valid   <= boot_valid_nx;
      busy         <= busy_nx;
    end
  end

  // Address and data come straight from registers and hold through WRITE.
  assign st_addr = word_cnt_q;
  assign st_data = word;

endmodule

// File: tb/tb_initial_orders_sequencer.sv
// Scoreboard bench for initial_orders_sequencer: stimulus queues expected store
// writes and boot pulses, an independent monitor checks what the DUT presents.
module tb_initial_orders_sequencer;

  localparam int unsigned WB = 17;
  localparam int unsigned NO = 31;
  localparam int unsigned AW = 10;
  localparam int          BOOT_LAT = 560;

  logic          clk = 1'b0;
  logic          rst, start, stop_req, serial_in, serial_valid, serial_ready;
  logic          st_we, st_ack, reset_sct, starter, boot_valid, busy;
  logic [AW-1:0] st_addr;
  logic [WB-1:0] st_data;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WB-1:0] data;
  } wr_t;

  wr_t     exp_wr[$];
  int      exp_boot[$];
  logic    bits[$];
  logic [WB-1:0] wv [NO];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_sct = 0;
  int   valid_mode = 0;
  int   ack_mode = 0;
  logic ack_manual = 1'b0;

  initial_orders_sequencer #(.WORD_BITS(WB), .NUM_ORDERS(NO), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop_req     (stop_req),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .st_we        (st_we),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ack       (st_ack),
    .reset_sct    (reset_sct),
    .starter      (starter),
    .boot_valid   (boot_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial source: presents queued bits, pops one per completed handshake.
  initial begin
    logic fire;
    serial_valid = 1'b0;
    serial_in    = 1'b0;
    forever begin
      @(negedge clk);
      fire = serial_valid && serial_ready;
      @(posedge clk);
      #1;
      if (fire && bits.size() > 0) void'(bits.pop_front());
      if (bits.size() > 0) begin
        serial_in    = bits[0];
        serial_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        serial_in    = 1'b0;
        serial_valid = 1'b0;
      end
    end
  end

  // Store model: immediate, random 0-5 cycle, or held-off-at-word-5 acknowledge.
  initial begin
    int wcnt;
    wcnt   = 0;
    st_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (st_we && !st_ack && !stop_req) wcnt++;
      else wcnt = 0;
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       st_ack = 1'b1;
        1:       st_ack = (wcnt >= 5) || ($urandom_range(0, 2) == 0);
        default: st_ack = (st_we && st_addr == AW'(5)) ? ack_manual : 1'b1;
      endcase
    end
  end

  // Monitor: commits, hold stability, ready during WRITE, boot pulses.
  initial begin
    logic          pv_we, pv_commit, pv_starter;
    logic [AW-1:0] pv_addr;
    logic [WB-1:0] pv_data;
    wr_t           w;
    int            e;
    pv_we = 1'b0; pv_commit = 1'b0; pv_starter = 1'b0; pv_addr = '0; pv_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (st_we) begin
          chk("ready_in_write", 32'(serial_ready), 32'(0));
          if (pv_we && !pv_commit) begin
            chk("addr_hold", 32'(st_addr), 32'(pv_addr));
            chk("data_hold", 32'(st_data), 32'(pv_data));
          end
          if (st_ack && !stop_req) begin
            if (exp_wr.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_write: got addr %0d data %0h, want no write", st_addr, st_data);
            end else begin
              w = exp_wr.pop_front();
              chk("wr_addr", 32'(st_addr), 32'(w.addr));
              chk("wr_data", 32'(st_data), 32'(w.data));
            end
          end
        end
        if (reset_sct) n_sct++;
        if (boot_valid) begin
          chk("starter_at_boot", 32'(starter), 32'(0));
          chk("starter_before_boot", 32'(pv_starter), 32'(1));
          if (exp_boot.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_boot: got boot_valid at cycle %0d, want none", cyc);
          end else begin
            e = exp_boot.pop_front();
            if (e >= 0) chk("boot_cycle", 32'(cyc), 32'(e));
          end
        end
      end
      pv_we      = st_we;
      pv_addr    = st_addr;
      pv_data    = st_data;
      pv_starter = starter;
      pv_commit  = st_we && st_ack && !stop_req;
    end
  end

  task automatic queue_load(input int n_exp);
    wr_t w;
    for (int i = 0; i < int'(NO); i++) begin
      for (int b = 0; b < int'(WB); b++) bits.push_back(wv[i][b]);
      if (i < n_exp) begin
        w.addr = AW'(i);
        w.data = wv[i];
        exp_wr.push_back(w);
      end
    end
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk);
    #1;
    start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_boot.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_wr.size() != 0 || exp_boot.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d writes and %0d boots outstanding, want 0",
               name, exp_wr.size(), exp_boot.size());
    end
    exp_wr.delete();
    exp_boot.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t, sct0, n;
    rst = 1'b1; start = 1'b1; stop_req = 1'b0;

    // Reset with start held high, then a full load at full rate.
    for (int i = 0; i < int'(NO); i++) wv[i] = WB'(i * 3);
    queue_load(NO);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl_outputs", 32'({busy, starter, st_we, reset_sct, boot_valid, serial_ready}), 32'(0));
    chk("rst_addr_data", 32'({st_addr, st_data}), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = cyc;
    exp_boot.push_back(t + BOOT_LAT);
    @(negedge clk);
    chk("idle_after_rst", 32'({reset_sct, starter, busy}), 32'(0));
    @(negedge clk);
    chk("clear_entered", 32'({reset_sct, starter, busy}), 32'(3'b111));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("full_load");
    chk("sct_pulses_first", 32'(n_sct), 32'(1));

    // Throttled source, delayed acks, and an ignored second start mid-load.
    valid_mode = 1; ack_mode = 1;
    queue_load(NO);
    exp_boot.push_back(-1);
    sct0 = n_sct;
    pulse_start(t);
    repeat (150) @(posedge clk);
    pulse_start(t);
    wait_drain("throttled_load");
    chk("sct_pulses_restart_ignored", 32'(n_sct - sct0), 32'(1));

    // Abort while word 5 waits for its ack, with the ack in the abort cycle.
    valid_mode = 0; ack_mode = 2; ack_manual = 1'b0;
    for (int i = 0; i < int'(NO); i++) wv[i] = WB'(17'h1F0F0 ^ (i * 17));
    queue_load(5);
    pulse_start(t);
    n = 0;
    while (!(st_we && st_addr == AW'(5)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("word5_write_seen", 32'(st_we && st_addr == AW'(5)), 32'(1));
    @(posedge clk);
    ack_manual = 1'b1;
    #1;
    stop_req = 1'b1;
    @(posedge clk);
    ack_manual = 1'b0;
    #1;
    stop_req = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({busy, starter, st_we, boot_valid}), 32'(0));
    repeat (10) @(negedge clk);
    chk("abort_writes_before", 32'(exp_wr.size()), 32'(0));
    bits.delete();

    // Reload from address 0; word 0 has only its first and last bits set.
    ack_mode = 0;
    wv[0] = 17'h10001;
    for (int i = 1; i < int'(NO); i++) wv[i] = WB'(17'h0AAAA ^ i);
    wv[NO-1] = 17'h1FFFF;
    queue_load(NO);
    sct0 = n_sct;
    pulse_start(t);
    exp_boot.push_back(t + BOOT_LAT);
    wait_drain("reload");
    chk("sct_pulses_reload", 32'(n_sct - sct0), 32'(1));
    chk("final_idle", 32'({busy, starter, st_we}), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
